// File: rtl/lutram_fifo_pkg.sv
// lutram_fifo_pkg: shared geometry and pointer/count types for the LUT-RAM FWFT FIFO.
package lutram_fifo_pkg;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/lutram_dp64.sv
// lutram_dp64: 64-deep dual-port distributed RAM, sync write / async read, one 64x1 cell per bit.
module lutram_dp64
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic [DEPTH-1:0] cell_q;
        always_ff @(posedge clk) begin
            if (we) cell_q[waddr] <= wdata[g];
        end
        assign rdata[g] = cell_q[raddr];
    end
endmodule

// File: rtl/lutram_fwft_fifo.sv
// lutram_fwft_fifo: 64-entry first-word-fall-through FIFO over distributed RAM with a registered head.
module lutram_fwft_fifo
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int AFULL_THRESH = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full
);
    ptr_t             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t             ram_cnt_q, ram_cnt_d, count_q, count_d;
    logic             out_valid_q, out_valid_d, wr_ready_q, almost_full_q;
    logic [WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;
    logic             push, pop, load;

    lutram_dp64 #(.WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Head register refills whenever it is empty or being consumed and RAM has data.
    always_comb begin
        push        = wr_valid & wr_ready_q;
        pop         = out_valid_q & rd_ready;
        load        = (ram_cnt_q != '0) & (~out_valid_q | rd_ready);
        wr_ptr_d    = flush ? '0 : wr_ptr_q + ptr_t'(push);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + ptr_t'(load);
        ram_cnt_d   = flush ? '0 : ram_cnt_q + cnt_t'(push) - cnt_t'(load);
        count_d     = flush ? '0 : count_q + cnt_t'(push) - cnt_t'(pop);
        out_valid_d = flush ? 1'b0 : (load | (out_valid_q & ~pop));
        rd_data_d   = (load & ~flush) ? ram_rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            rd_data_q     <= '0;
            wr_ready_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            rd_data_q     <= rd_data_d;
            wr_ready_q    <= count_d < cnt_t'(DEPTH);
            almost_full_q <= count_d >= cnt_t'(AFULL_THRESH);
        end
    end

    assign wr_ready    = wr_ready_q;
    assign rd_valid    = out_valid_q;
    assign rd_data     = rd_data_q;
    assign count       = count_q;
    assign almost_full = almost_full_q;
endmodule

// File: tb/tb_lutram_fwft_fifo.sv
// tb_lutram_fwft_fifo: directed self-checking bench for lutram_fwft_fifo.
module tb_lutram_fwft_fifo;
    logic       clk = 1'b0;
    logic       rst_n, flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full;
    logic [7:0] wr_data, rd_data;
    logic [6:0] count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    lutram_fwft_fifo #(.WIDTH(8), .AFULL_THRESH(56)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        // reset and single write
        repeat (3) tick();
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_wr_ready", wr_ready, 1);
        push_n(1, 8'hA5);
        chk("single_count", count, 1);
        chk("single_no_bypass", rd_valid, 0);
        tick();
        chk("single_rd_valid", rd_valid, 1);
        chk("single_rd_data", rd_data, 8'hA5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_pop_count", count, 0);
        chk("single_pop_valid", rd_valid, 0);
        // fill to full
        for (int i = 0; i < 64; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
            chk("fill_count", count, i + 1);
            chk("fill_afull", almost_full, (i + 1) >= 56);
            chk("fill_wr_ready", wr_ready, (i + 1) < 64);
        end
        wr_data = 8'hEE;
        tick();
        wr_valid = 1'b0;
        chk("full_ignore_count", count, 64);
        chk("full_ignore_ready", wr_ready, 0);
        // drain 32, refill 32 across the pointer wrap, drain all
        for (int i = 0; i < 32; i++) begin
            chk("drain1_valid", rd_valid, 1);
            chk("drain1_data", rd_data, i);
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        chk("drain1_count", count, 32);
        push_n(32, 8'h40);
        chk("refill_count", count, 64);
        for (int i = 32; i < 96; i++) begin
            chk("drain2_valid", rd_valid, 1);
            chk("drain2_data", rd_data, i);
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        chk("drain2_count", count, 0);
        chk("drain2_valid_end", rd_valid, 0);
        chk("drain2_afull", almost_full, 0);
        // steady push+pop at count 10
        push_n(10, 8'h80);
        tick();
        chk("pp_start_count", count, 10);
        for (int k = 0; k < 20; k++) begin
            chk("pp_valid", rd_valid, 1);
            chk("pp_data", rd_data, 8'h80 + k);
            chk("pp_count", count, 10);
            wr_valid = 1'b1;
            wr_data  = 8'h8A + 8'(k);
            rd_ready = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        for (int k = 20; k < 30; k++) begin
            chk("pp_drain_valid", rd_valid, 1);
            chk("pp_drain_data", rd_data, 8'h80 + k);
            tick();
        end
        rd_ready = 1'b0;
        chk("pp_end_count", count, 0);
        chk("pp_end_valid", rd_valid, 0);
        // full plus simultaneous pop
        push_n(64, 8'h00);
        tick();
        chk("fp_count", count, 64);
        chk("fp_wr_ready", wr_ready, 0);
        wr_valid = 1'b1; wr_data = 8'hFF; rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("fp_count_after", count, 63);
        chk("fp_wr_ready_after", wr_ready, 1);
        chk("fp_head", rd_data, 1);
        chk("fp_afull", almost_full, 1);
        // flush mid-stream
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl0_count", count, 0);
        chk("fl0_wr_ready", wr_ready, 1);
        push_n(20, 8'h30);
        tick();
        chk("fl_pre_count", count, 20);
        chk("fl_pre_head", rd_data, 8'h30);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h55; rd_ready = 1'b1;
        tick();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_rd_valid", rd_valid, 0);
        chk("fl_wr_ready", wr_ready, 1);
        chk("fl_afull", almost_full, 0);
        chk("fl_rd_data_kept", rd_data, 8'h30);
        tick();
        chk("fl_no_pulse", rd_valid, 0);
        chk("fl_no_pulse_count", count, 0);
        push_n(1, 8'h77);
        tick();
        chk("fl_post_valid", rd_valid, 1);
        chk("fl_post_data", rd_data, 8'h77);
        chk("fl_post_count", count, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
